polyunit_loader: RTL and testbench

//  Upstream sequencer for polyunit_core2. Accepts a 12-bit coefficient stream (valid/ready),

---
 rtl/polyunit_loader_if.sv | 27 ++
 rtl/polyunit_loader.sv | 194 +++++++++++++++++++
 tb/tb_polyunit_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/polyunit_loader_if.sv
// Bundle for the loader: coefficient stream on one side, core data/strobe port on the other.
// The loader connects through the slave modport; the environment or bench uses master.
interface polyunit_loader_if #(
  parameter int WID = 12,
  parameter int AW  = 5
);
  logic [WID-1:0]   coef_in;
  logic             coef_valid;
  logic             coef_ready;
  logic             op_intt;
  logic [4*WID-1:0] data_in;
  logic [AW-1:0]    data_in_add;
  logic             data_in_done;
  logic [1:0]       mode;
  logic             run;
  logic             core_done;

  modport master (
    output coef_in, coef_valid, op_intt, core_done,
    input  coef_ready, data_in, data_in_add, data_in_done, mode, run
  );

  modport slave (
    input  coef_in, coef_valid, op_intt, core_done,
    output coef_ready, data_in, data_in_add, data_in_done, mode, run
  );
endinterface

// File: rtl/polyunit_loader.sv
// Sequencer in front of polyunit_core2: collects and reduces one polynomial, bursts it into
// the core, launches NTT/INTT and waits for the core to report completion.
//
// state      | meaning
// S_FILL     | accept coefficients, reduce mod Q, store into the local buffer
// S_LOAD_RUN | run pulse with mode DATAIN
// S_BURST    | one packed word per cycle to the core, address 0..NWORDS-1
// S_DIN_DONE | data_in_done pulse, data bus holds the last word
// S_GAP_WAIT | idle GAP cycles, all strobes low
// S_OP_RUN   | run pulse with mode NTT or INTT
// S_OP_WAIT  | hold mode until core_done
// S_FINISH   | done pulse, then back to S_FILL
module polyunit_loader #(
  parameter int WID    = 12,
  parameter int Q      = 3329,
  parameter int NWORDS = 32,
  parameter int GAP    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  polyunit_loader_if.slave        bus,
  output logic                    busy,
  output logic                    done
);
  localparam int NCOEF = 4 * NWORDS;
  localparam int AW    = $clog2(NWORDS);
  localparam int CW    = AW + 2;
  localparam int GW    = $clog2(GAP + 1);

  localparam logic [1:0] MODE_NTT    = 2'd0;
  localparam logic [1:0] MODE_DATAIN = 2'd2;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD_RUN,
    S_BURST,
    S_DIN_DONE,
    S_GAP_WAIT,
    S_OP_RUN,
    S_OP_WAIT,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [WID-1:0]   mem [NCOEF];
  logic [CW-1:0]    cnt;
  logic             op_latch;
  logic [4*WID-1:0] word_q;
  logic [AW-1:0]    add_q;
  logic [GW-1:0]    gap_cnt;

  logic             accept;
  logic             last_coef;
  logic             last_word;
  logic [WID-1:0]   coef_red;
  logic [AW-1:0]    rd_add;
  logic [4*WID-1:0] rd_word;

  logic             ready_c;
  logic             run_c;
  logic [1:0]       mode_c;
  logic             din_done_c;
  logic             done_c;

  // Inputs stay below 2Q, so a single conditional subtract is a full reduction.
  always_comb begin
    coef_red = bus.coef_in;
    if (bus.coef_in >= WID'(Q))
      coef_red = bus.coef_in - WID'(Q);
  end

  assign accept    = bus.coef_valid & ready_c;
  assign last_coef = (cnt == CW'(NCOEF - 1));
  assign last_word = (add_q == AW'(NWORDS - 1));

  // The burst word is registered one cycle ahead, so LOAD_RUN prefetches word 0.
  assign rd_add = (state == S_LOAD_RUN) ? '0 : add_q + AW'(1);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++)
      rd_word[k*WID +: WID] = mem[{rd_add, 2'(k)}];
  end

  always_ff @(posedge clk) begin
    if (state == S_FILL && accept)
      mem[cnt] <= coef_red;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_FILL;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_latch <= 1'b0;
      word_q   <= '0;
      add_q    <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            if (last_coef) begin
              cnt      <= '0;
              op_latch <= bus.op_intt;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_LOAD_RUN: begin
          word_q <= rd_word;
          add_q  <= rd_add;
        end
        S_BURST: begin
          if (!last_word) begin
            word_q <= rd_word;
            add_q  <= rd_add;
          end
        end
        S_DIN_DONE: gap_cnt <= GW'(GAP - 1);
        S_GAP_WAIT: begin
          if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    run_c      = 1'b0;
    mode_c     = MODE_NTT;
    din_done_c = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_FILL: begin
        ready_c = 1'b1;
        if (accept && last_coef)
          state_nxt = S_LOAD_RUN;
      end
      S_LOAD_RUN: begin
        run_c     = 1'b1;
        mode_c    = MODE_DATAIN;
        state_nxt = S_BURST;
      end
      S_BURST: begin
        if (last_word)
          state_nxt = S_DIN_DONE;
      end
      S_DIN_DONE: begin
        din_done_c = 1'b1;
        state_nxt  = S_GAP_WAIT;
      end
      S_GAP_WAIT: begin
        if (gap_cnt == '0)
          state_nxt = S_OP_RUN;
      end
      S_OP_RUN: begin
        run_c     = 1'b1;
        mode_c    = {1'b0, op_latch};
        state_nxt = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        mode_c = {1'b0, op_latch};
        if (bus.core_done)
          state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done_c    = 1'b1;
        state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  assign bus.coef_ready   = ready_c;
  assign bus.run          = run_c;
  assign bus.mode         = mode_c;
  assign bus.data_in_done = din_done_c;
  assign bus.data_in      = word_q;
  assign bus.data_in_add  = add_q;
  assign busy             = (state != S_FILL);
  assign done             = done_c;

endmodule

// File: tb/tb_polyunit_loader.sv
// Directed bench for polyunit_loader: ramp, reduction, bursty valid, INTT with long wait,
// reset mid-burst and spurious core_done, checked against a small packing model.
module tb_polyunit_loader;
  logic clk = 1'b0;
  logic rst;
  logic busy, done;

  always #5 clk = ~clk;

  polyunit_loader_if #(.WID(12), .AW(5)) bus ();

  polyunit_loader #(.WID(12), .Q(3329), .NWORDS(32), .GAP(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] coefs [128];
  logic [47:0] exp_w [32];
  logic [47:0] got_w [32];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] red(input logic [11:0] c);
    return (c >= 12'd3329) ? c - 12'd3329 : c;
  endfunction

  task automatic build_model;
    for (int w = 0; w < 32; w++)
      exp_w[w] = {red(coefs[4*w+3]), red(coefs[4*w+2]), red(coefs[4*w+1]), red(coefs[4*w])};
  endtask

  // Presents all 128 coefficients; returns with the DUT in its LOAD_RUN cycle.
  task automatic load(input bit bursty, input bit op, output int cycles);
    int stalls;
    int g;
    cycles = 0;
    for (int n = 0; n < 128; n++) begin
      if (bursty) begin
        bus.coef_valid = 1'b0;
        stalls = (n % 2 == 0) ? 1 + int'($urandom_range(0, 2)) : 0;
        repeat (stalls) begin
          tick;
          cycles++;
        end
      end
      bus.coef_in    = coefs[n];
      bus.op_intt    = (n == 127) ? op : 1'b0;
      bus.coef_valid = 1'b1;
      g = 0;
      while (bus.coef_ready !== 1'b1 && g < 1000) begin
        tick;
        g++;
        cycles++;
      end
      if (g >= 1000) begin
        check("ready_timeout", 48'(g), 48'd0);
        bus.coef_valid = 1'b0;
        return;
      end
      tick;
      cycles++;
    end
    bus.coef_valid = 1'b0;
    bus.op_intt    = 1'b0;
  endtask

  // Walks LOAD_RUN .. OP_WAIT; abort_at >= 0 returns while burst word abort_at is on the bus.
  task automatic run_seq(input bit op, input bit cd_force, input int abort_at);
    int viol;
    viol = 0;
    check("ldrun_run",   48'(bus.run), 48'd1);
    check("ldrun_mode",  48'(bus.mode), 48'd2);
    check("ldrun_ready", 48'(bus.coef_ready), 48'd0);
    check("ldrun_busy",  48'(busy), 48'd1);
    bus.core_done = cd_force;
    for (int i = 0; i < 32; i++) begin
      tick;
      got_w[i] = bus.data_in;
      check("burst_word", bus.data_in, exp_w[i]);
      check("burst_add",  48'(bus.data_in_add), 48'(i));
      if (bus.run || bus.mode != 2'd0 || bus.data_in_done || done || bus.coef_ready) viol++;
      if (i == abort_at) return;
    end
    tick;
    check("dind_pulse", 48'(bus.data_in_done), 48'd1);
    check("dind_word",  bus.data_in, exp_w[31]);
    check("dind_add",   48'(bus.data_in_add), 48'd31);
    check("dind_run",   48'(bus.run), 48'd0);
    for (int g = 0; g < 16; g++) begin
      tick;
      if (bus.run || bus.mode != 2'd0 || bus.data_in_done || done || bus.coef_ready) viol++;
    end
    tick;
    check("oprun_run",  48'(bus.run), 48'd1);
    check("oprun_mode", 48'(bus.mode), 48'(op));
    tick;
    bus.core_done = 1'b0;
    check("opwait_run",  48'(bus.run), 48'd0);
    check("opwait_mode", 48'(bus.mode), 48'(op));
    check("opwait_done", 48'(done), 48'd0);
    check("opwait_busy", 48'(busy), 48'd1);
    check("quiet_viol",  48'(viol), 48'd0);
  endtask

  // Starts in OP_WAIT, waits wait_cycles, then pulses core_done.
  task automatic complete(input int wait_cycles, input bit op);
    int viol;
    viol = 0;
    for (int k = 0; k < wait_cycles; k++) begin
      tick;
      if (busy !== 1'b1 || bus.mode !== {1'b0, op} || done !== 1'b0 || bus.coef_ready !== 1'b0) viol++;
    end
    check("wait_viol", 48'(viol), 48'd0);
    bus.core_done = 1'b1;
    tick;
    bus.core_done = 1'b0;
    check("fin_done",  48'(done), 48'd1);
    check("fin_ready", 48'(bus.coef_ready), 48'd0);
    check("fin_busy",  48'(busy), 48'd1);
    check("fin_mode",  48'(bus.mode), 48'd0);
    tick;
    check("idle_done",  48'(done), 48'd0);
    check("idle_ready", 48'(bus.coef_ready), 48'd1);
    check("idle_busy",  48'(busy), 48'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst            = 1'b1;
    bus.coef_in    = '0;
    bus.coef_valid = 1'b0;
    bus.op_intt    = 1'b0;
    bus.core_done  = 1'b0;
    repeat (3) tick;
    check("rst_ready", 48'(bus.coef_ready), 48'd1);
    check("rst_busy",  48'(busy), 48'd0);
    check("rst_run",   48'(bus.run), 48'd0);
    check("rst_mode",  48'(bus.mode), 48'd0);
    check("rst_dind",  48'(bus.data_in_done), 48'd0);
    check("rst_done",  48'(done), 48'd0);
    check("rst_data",  bus.data_in, 48'd0);
    check("rst_add",   48'(bus.data_in_add), 48'd0);
    rst = 1'b0;

    // Ramp, NTT
    for (int n = 0; n < 128; n++) coefs[n] = 12'(n);
    build_model;
    load(1'b0, 1'b0, cyc);
    check("s1_cycles", 48'(cyc), 48'd128);
    run_seq(1'b0, 1'b0, -1);
    check("s1_word0",  got_w[0],  48'h003_002_001_000);
    check("s1_word31", got_w[31], 48'h07F_07E_07D_07C);
    complete(3, 1'b0);

    // Reduction boundaries
    coefs[0] = 12'd3328;
    coefs[1] = 12'd3329;
    coefs[2] = 12'd4095;
    coefs[3] = 12'd0;
    build_model;
    load(1'b0, 1'b0, cyc);
    run_seq(1'b0, 1'b0, -1);
    check("s2_word0", got_w[0], {12'd0, 12'd766, 12'd0, 12'd3328});
    complete(2, 1'b0);

    // Bursty valid, ramp data again
    for (int n = 0; n < 128; n++) coefs[n] = 12'(n);
    build_model;
    load(1'b1, 1'b0, cyc);
    run_seq(1'b0, 1'b0, -1);
    check("s3_word0",  got_w[0],  48'h003_002_001_000);
    check("s3_word31", got_w[31], 48'h07F_07E_07D_07C);
    complete(4, 1'b0);

    // INTT with a long core wait
    for (int n = 0; n < 128; n++) coefs[n] = 12'(3000 + n * 5);
    build_model;
    load(1'b0, 1'b1, cyc);
    run_seq(1'b1, 1'b0, -1);
    complete(500, 1'b1);

    // Reset in the middle of the burst
    for (int n = 0; n < 128; n++) coefs[n] = 12'(127 - n);
    build_model;
    load(1'b0, 1'b0, cyc);
    run_seq(1'b0, 1'b0, 10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("s5_ready", 48'(bus.coef_ready), 48'd1);
    check("s5_busy",  48'(busy), 48'd0);
    check("s5_run",   48'(bus.run), 48'd0);
    check("s5_mode",  48'(bus.mode), 48'd0);
    check("s5_dind",  48'(bus.data_in_done), 48'd0);
    check("s5_add",   48'(bus.data_in_add), 48'd0);
    tick;
    check("s5_idle_busy", 48'(busy), 48'd0);
    for (int n = 0; n < 128; n++) coefs[n] = 12'(n * 7 + 1);
    build_model;
    load(1'b0, 1'b1, cyc);
    check("s5_cycles", 48'(cyc), 48'd128);
    run_seq(1'b1, 1'b0, -1);
    complete(5, 1'b1);

    // core_done held high through FILL, BURST and OP_RUN
    for (int n = 0; n < 128; n++) coefs[n] = 12'(4095 - n);
    build_model;
    bus.core_done = 1'b1;
    load(1'b0, 1'b0, cyc);
    check("s6_cycles", 48'(cyc), 48'd128);
    run_seq(1'b0, 1'b1, -1);
    complete(6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
